// File: rtl/kbd_pkg.sv
// Shared definitions for the keypad reader: register map,
// code width and the row-scan state encoding.
package kbd_pkg;

    localparam logic [31:0] KBD_DATA_ADDR   = 32'hFFFF_F010;
    localparam logic [31:0] KBD_STATUS_ADDR = 32'hFFFF_F014;
    localparam logic [31:0] KBD_DOWN_ADDR   = 32'hFFFF_F018;

    localparam int KEY_CODE_W = 4;

    typedef enum logic [1:0] {
        ROW0,
        ROW1,
        ROW2,
        ROW3
    } scan_state_t;

    // Lowest key index wins when several keys go down together
    function automatic logic [KEY_CODE_W-1:0] lowest_idx(
        input logic [15:0] v
    );
        lowest_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) lowest_idx = KEY_CODE_W'(i);
        end
    endfunction

endpackage

// File: rtl/keypad_reader_if.sv
// CPU read port of the keypad reader.
// The CPU side drives address and strobe, the reader returns data.
interface keypad_reader_if;

    logic [31:0] addra;
    logic        ren;
    logic [31:0] rdata;

    modport master (
        output addra,
        output ren,
        input  rdata
    );

    modport slave (
        input  addra,
        input  ren,
        output rdata
    );

endinterface

// File: rtl/kbd_scan.sv
// Row scanner: drives one row low at a time, synchronises the
// columns and assembles a 16-bit raw frame with a done pulse.
module kbd_scan
    import kbd_pkg::*;
#(
    parameter int SCAN_CYCLES = 50000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_col_n,
    output logic [3:0]  o_row_n,
    output logic [15:0] o_raw,
    output logic        o_frame_done
);

    localparam int DW = $clog2(SCAN_CYCLES);
    localparam logic [DW-1:0] LAST = DW'(SCAN_CYCLES - 1);

    scan_state_t r_state;
    logic [DW-1:0] r_dwell;
    logic [3:0]    r_row_n;
    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [15:0]   r_raw;
    logic          r_frame_done;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ROW0;
            r_dwell      <= '0;
            r_row_n      <= 4'b1110;
            r_sync1      <= 4'hF;
            r_sync2      <= 4'hF;
            r_raw        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_sync1      <= i_col_n;
            r_sync2      <= r_sync1;
            r_frame_done <= 1'b0;
            if (r_dwell != LAST) begin
                r_dwell <= r_dwell + 1'b1;
            end else begin
                r_dwell <= '0;
                // Sample this row, then hand the drive to the next one
                unique case (r_state)
                    ROW0: begin
                        r_raw[3:0] <= ~r_sync2;
                        r_state    <= ROW1;
                        r_row_n    <= 4'b1101;
                    end
                    ROW1: begin
                        r_raw[7:4] <= ~r_sync2;
                        r_state    <= ROW2;
                        r_row_n    <= 4'b1011;
                    end
                    ROW2: begin
                        r_raw[11:8] <= ~r_sync2;
                        r_state     <= ROW3;
                        r_row_n     <= 4'b0111;
                    end
                    ROW3: begin
                        r_raw[15:12] <= ~r_sync2;
                        r_state      <= ROW0;
                        r_row_n      <= 4'b1110;
                        r_frame_done <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign o_row_n      = r_row_n;
    assign o_raw        = r_raw;
    assign o_frame_done = r_frame_done;

endmodule

// File: rtl/keypad_reader.sv
// Memory-mapped 4x4 keypad reader: frame debounce, new-press
// latch with overrun tracking, and a combinational read mux.
module keypad_reader
    import kbd_pkg::*;
#(
    parameter int SCAN_CYCLES    = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic            clk,
    input  logic            rst,
    keypad_reader_if.slave  bus,
    output logic [3:0]      row_n,
    input  logic [3:0]      col_n
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_SCANS);

    logic [15:0]           w_raw;
    logic                  w_frame_done;
    logic                  w_stable;
    logic [CW-1:0]         w_cnt_inc;
    logic [15:0]           w_down_next;
    logic [15:0]           w_new;
    logic                  w_clr;

    logic [15:0]           r_prev_raw;
    logic [CW-1:0]         r_stable_cnt;
    logic [15:0]           r_down;
    logic [KEY_CODE_W-1:0] r_code;
    logic                  r_valid;
    logic                  r_overrun;

    kbd_scan #(
        .SCAN_CYCLES (SCAN_CYCLES)
    ) u_scan (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_col_n      (col_n),
        .o_row_n      (row_n),
        .o_raw        (w_raw),
        .o_frame_done (w_frame_done)
    );

    always_comb begin
        w_stable  = (w_raw == r_prev_raw);
        w_cnt_inc = (r_stable_cnt == DB_MAX) ? DB_MAX
                                             : r_stable_cnt + 1'b1;
        w_down_next = r_down;
        if (w_frame_done && w_stable && w_cnt_inc == DB_MAX)
            w_down_next = w_raw;
        w_new = w_down_next & ~r_down;
        w_clr = bus.ren && (bus.addra == KBD_DATA_ADDR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_raw   <= '0;
            r_stable_cnt <= '0;
            r_down       <= '0;
            r_code       <= '0;
            r_valid      <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_frame_done) begin
                r_prev_raw   <= w_raw;
                r_stable_cnt <= w_stable ? w_cnt_inc : '0;
            end
            r_down <= w_down_next;
            // A new press beats a clearing read on the same edge
            if (|w_new) begin
                r_code    <= lowest_idx(w_new);
                r_valid   <= 1'b1;
                r_overrun <= w_clr ? 1'b0 : (r_overrun | r_valid);
            end else if (w_clr) begin
                r_valid   <= 1'b0;
                r_overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        bus.rdata = '0;
        unique case (1'b1)
            (bus.addra == KBD_DATA_ADDR):   bus.rdata = 32'(r_code);
            (bus.addra == KBD_STATUS_ADDR): bus.rdata = {30'b0, r_overrun, r_valid};
            (bus.addra == KBD_DOWN_ADDR):   bus.rdata = {16'b0, r_down};
            default:                        bus.rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_keypad_reader.sv
// Directed bench for keypad_reader with a behavioural 4x4 matrix,
// SCAN_CYCLES=4 and DEBOUNCE_SCANS=2 (16-cycle frames).
module tb_keypad_reader;
    import kbd_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [15:0] keys = '0;
    int          total = 0;
    int          bad = 0;

    keypad_reader_if bus ();

    keypad_reader #(
        .SCAN_CYCLES    (4),
        .DEBOUNCE_SCANS (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .row_n (row_n),
        .col_n (col_n)
    );

    always #5 clk = ~clk;

    // Matrix model: a pressed key pulls its column low while its row is driven
    always_comb begin
        col_n = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!row_n[r]) col_n = col_n & ~keys[r*4 +: 4];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [31:0] a,
                      input logic [31:0] exp);
        bus.addra = a;
        #1;
        chk(tag, bus.rdata, exp);
    endtask

    // Ends on the first negedge of a new frame
    task automatic to_frame_end();
        int n = 0;
        while (row_n == 4'b1110 && n < 64) begin
            @(negedge clk);
            n++;
        end
        while (row_n != 4'b1110 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("frame_timeout", 32'(n < 64), 32'd1);
    endtask

    // Also lets the frame-end update settle into the registers
    task automatic next_frame();
        to_frame_end();
        @(negedge clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) next_frame();
    endtask

    task automatic clr_read();
        bus.addra = KBD_DATA_ADDR;
        bus.ren   = 1'b1;
        @(negedge clk);
        bus.ren   = 1'b0;
    endtask

    initial begin
        int n;
        bus.addra = '0;
        bus.ren   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_row", 32'(row_n), 32'h0000000E);
        rd("rst_data", KBD_DATA_ADDR, 32'h0);
        rd("rst_status", KBD_STATUS_ADDR, 32'h0);
        rd("rst_down", KBD_DOWN_ADDR, 32'h0);
        rst = 1'b0;

        // Row rotation, 4 cycles per row
        repeat (4) @(negedge clk);
        chk("rot_row1", 32'(row_n), 32'hD);
        repeat (4) @(negedge clk);
        chk("rot_row2", 32'(row_n), 32'hB);
        repeat (4) @(negedge clk);
        chk("rot_row3", 32'(row_n), 32'h7);
        repeat (4) @(negedge clk);
        chk("rot_row0", 32'(row_n), 32'hE);
        rd("idle_down", KBD_DOWN_ADDR, 32'h0);

        // Key 6 (row1, col2)
        keys = 16'h0040;
        frames(2);
        rd("k6_early", KBD_STATUS_ADDR, 32'h0);
        next_frame();
        rd("k6_status", KBD_STATUS_ADDR, 32'h1);
        rd("k6_data", KBD_DATA_ADDR, 32'h6);
        rd("k6_down", KBD_DOWN_ADDR, 32'h0040);
        rd("k6_hole", 32'hFFFFF01C, 32'h0);
        clr_read();
        rd("k6_clr_status", KBD_STATUS_ADDR, 32'h0);
        rd("k6_clr_data", KBD_DATA_ADDR, 32'h6);

        // Release never sets valid
        next_frame();
        keys = 16'h0;
        frames(3);
        rd("rel_down", KBD_DOWN_ADDR, 32'h0);
        rd("rel_status", KBD_STATUS_ADDR, 32'h0);

        // Bounce key 0 for 5 frames, then hold
        for (int i = 0; i < 5; i++) begin
            keys = (i % 2 == 1) ? 16'h0001 : 16'h0000;
            next_frame();
            rd("bounce_status", KBD_STATUS_ADDR, 32'h0);
        end
        keys = 16'h0001;
        frames(2);
        rd("hold_early", KBD_STATUS_ADDR, 32'h0);
        next_frame();
        rd("hold_status", KBD_STATUS_ADDR, 32'h1);
        rd("hold_data", KBD_DATA_ADDR, 32'h0);
        rd("hold_down", KBD_DOWN_ADDR, 32'h0001);
        clr_read();
        rd("hold_clr", KBD_STATUS_ADDR, 32'h0);

        // Key 3 unread, release, key 9 -> overrun
        next_frame();
        keys = 16'h0009;
        frames(3);
        rd("k3_data", KBD_DATA_ADDR, 32'h3);
        rd("k3_status", KBD_STATUS_ADDR, 32'h1);
        keys = 16'h0001;
        frames(3);
        rd("k3_rel_down", KBD_DOWN_ADDR, 32'h0001);
        rd("k3_rel_status", KBD_STATUS_ADDR, 32'h1);
        keys = 16'h0201;
        frames(3);
        rd("ovr_data", KBD_DATA_ADDR, 32'h9);
        rd("ovr_status", KBD_STATUS_ADDR, 32'h3);
        rd("ovr_down", KBD_DOWN_ADDR, 32'h0201);
        clr_read();
        rd("ovr_clr", KBD_STATUS_ADDR, 32'h0);

        // Keys 5 and 10 in the same frame
        next_frame();
        keys = 16'h0;
        frames(3);
        rd("pair_idle", KBD_DOWN_ADDR, 32'h0);
        keys = 16'h0420;
        frames(3);
        rd("pair_data", KBD_DATA_ADDR, 32'h5);
        rd("pair_down", KBD_DOWN_ADDR, 32'h0420);
        rd("pair_status", KBD_STATUS_ADDR, 32'h1);
        keys = 16'h0020;
        frames(3);
        rd("k10_rel_down", KBD_DOWN_ADDR, 32'h0020);
        keys = 16'h0420;
        frames(2);
        rd("k10_pre", KBD_STATUS_ADDR, 32'h1);
        // Clearing read lands on the edge where key 10 re-press latches
        to_frame_end();
        clr_read();
        rd("coll_status", KBD_STATUS_ADDR, 32'h1);
        rd("coll_data", KBD_DATA_ADDR, 32'hA);
        rd("coll_down", KBD_DOWN_ADDR, 32'h0420);

        // Reset mid-row2 with keys held
        clr_read();
        rd("pre_rst_status", KBD_STATUS_ADDR, 32'h0);
        n = 0;
        while (row_n != 4'b1011 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("row2_timeout", 32'(n < 64), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_row", 32'(row_n), 32'hE);
        rd("mid_rst_down", KBD_DOWN_ADDR, 32'h0);
        rd("mid_rst_data", KBD_DATA_ADDR, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        frames(2);
        rd("post_rst_early", KBD_STATUS_ADDR, 32'h0);
        rd("post_rst_down0", KBD_DOWN_ADDR, 32'h0);
        next_frame();
        rd("post_rst_status", KBD_STATUS_ADDR, 32'h1);
        rd("post_rst_data", KBD_DATA_ADDR, 32'h5);
        rd("post_rst_down", KBD_DOWN_ADDR, 32'h0420);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_reader.md
# keypad_reader

Memory-mapped 4x4 matrix keypad reader occupying the keyboard window 0xFFFFF010–0xFFFFF05F of the CPU data bus. It is the input-side counterpart to the display writer. The block scans rows, synchronises and debounces the columns, and latches the code of each new key press. The CPU reads the latched code, a status word and the live key bitmap through a combinational read port. The bus decoder selects this block's rdata when the address falls in the window.

## Interface
- SCAN_CYCLES, 50000: clock cycles each row is driven before its columns are sampled (≥2)
- DEBOUNCE_SCANS, 4: consecutive identical full frames required before the debounced bitmap updates (≥1)
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- addra  in  32  CPU byte address, full width
- ren  in  1  one-cycle read strobe, qualified by the bus decoder's keyboard window select
- rdata  out  32  read data, combinational from addra
- row_n  out  4  row drive, active-low, exactly one bit low at a time
- col_n  in  4  column sense, active-low, asynchronous to clk

## Operation
- Registers, word addresses:
  - 0xFFFFF010 KEY_DATA: bits [3:0] are the latched code, where code = row*4 + col. Other bits read 0. A ren here clears valid and overrun.
  - 0xFFFFF014 KEY_STATUS: bit [0] is valid, bit [1] is overrun. Read has no side effect.
  - 0xFFFFF018 KEY_DOWN: bits [15:0] are the debounced bitmap, with bit index equal to the key code. Read has no side effect.
  - Any other address in the window reads 0x00000000.
- Scan state machine:
  - States are ROW0, ROW1, ROW2 and ROW3, cycling ROW3 → ROW0.
  - A dwell counter counts 0..SCAN_CYCLES-1 in each state.
  - On the last dwell cycle, the synchronised columns are sampled into raw[row*4 +: 4] as pressed=1. The state then advances.
- Column synchroniser: two flops per column, reset value 1.
- Frame end, after the ROW3 sample:
  - raw is compared with prev_raw and prev_raw <= raw.
  - If they are equal, stable_cnt increments, saturating at DEBOUNCE_SCANS. If they differ, stable_cnt is cleared to 0.
  - When the incremented count reaches DEBOUNCE_SCANS, down <= raw.
- New-press detection, in the cycle down changes:
  - new = down_next & ~down.
  - If new is non-zero, code <= index of the lowest set bit of new, and valid <= 1.
  - If valid was already 1 and no clearing read occurs in the same cycle, overrun <= 1 and code is still overwritten.
- A key release never sets valid.
- Simultaneous clearing read and new press: the set wins, giving valid=1, code=new and overrun=0.
- Ghosting from three or more keys is not suppressed; the bitmap reflects the raw matrix.

## Timing
- Reset values:
  - row_n = 4'b1110, state ROW0, dwell counter 0.
  - raw, prev_raw and down are 0; stable_cnt 0.
  - code 0, valid 0, overrun 0.
  - Synchroniser flops are 1.
  - rdata is then 0 for all addresses.
- Frame length is 4*SCAN_CYCLES cycles.
- A press stable across the whole interval sets valid at the end of frame DEBOUNCE_SCANS+1 after its first full sampled frame, at the latest.
- rdata has zero latency and follows addra combinationally. The read-clear takes effect at the clk edge on which ren is high.
- Column sample-to-raw latency: 2 cycles of synchronisation, already absorbed since the sample is taken at the end of a ≥2-cycle dwell.
- Reset asserted mid-scan: all state returns to the reset values immediately. No partial frame is used afterwards.

## Structure
- Shared package kbd_pkg holds:
  - Register addresses KBD_DATA_ADDR, KBD_STATUS_ADDR and KBD_DOWN_ADDR.
  - KEY_CODE_W = 4.
  - Scan state encoding.
- Sub-module kbd_scan contains the row FSM, dwell counter, column synchroniser and raw frame assembly. It outputs raw[15:0] plus a one-cycle frame_done pulse.
- The top level contains the debounce comparator, the event/latch logic and the read mux.

## Test plan
All scenarios use SCAN_CYCLES=4 and DEBOUNCE_SCANS=2.
- Reset with no keys → row_n=1110; row_n rotates 1101, 1011, 0111 every 4 cycles; all three registers read 0.
- Key (row1, col2) held (col_n[2]=0 whenever row_n[1]=0) → after ≤3 frames KEY_STATUS=1, KEY_DATA=6, KEY_DOWN=0x0040. A ren on 0xFFFFF010 → KEY_STATUS=0 on the next cycle.
- Key toggles every frame (bounce) for 5 frames, then holds key 0 → no valid during bouncing; valid and code 0 arrive only after 2 stable frames.
- Key 3 press is not read, release, then key 9 press → KEY_DATA=9 and KEY_STATUS=3 (overrun). A ren on 0xFFFFF010 clears it to 0.
- Keys 5 and 10 are pressed in the same frame → KEY_DATA=5, KEY_DOWN=0x0420. A ren landing on the same edge that key 10's later re-press event fires → KEY_STATUS=1, overrun 0.
- rst pulse mid-row2 with key held → the outputs immediately take their reset values; a full debounce is required again before valid is set.
